// File: rtl/day_ctrl_pkg.sv
// Shared constants and state encoding for the day-counter run/pause/step/speed controller.
package day_ctrl_pkg;

  localparam int DEF_DIV_SLOW        = 32'sd5_000_000;
  localparam int DEF_DIV_FAST        = 32'sd1_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 32'sd200_000;
  localparam int DEF_HOLD_CYCLES     = 32'sd15_000_000;

  // Encoding 2'd3 is never entered on purpose; the FSM recovers it to ST_CLEAR.
  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_PAUSE = 2'd1,
    ST_RUN   = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/day_counter_ctrl_if.sv
// Key inputs and counter-enable/status outputs of the day-counter controller.
interface day_counter_ctrl_if;
  import day_ctrl_pkg::*;

  logic [1:0]  KEY;
  logic        tick;
  logic        clear;
  logic        running;
  logic        fast;
  ctrl_state_e ctrl_state;

  modport master (
    output KEY,
    input  tick,
    input  clear,
    input  running,
    input  fast,
    input  ctrl_state
  );

  modport slave (
    input  KEY,
    output tick,
    output clear,
    output running,
    output fast,
    output ctrl_state
  );

endinterface

// File: rtl/day_counter_ctrl_chk.sv
// Invariants of the controller outputs: exclusive enables, running mirrors the RUN state.
module day_counter_ctrl_chk
  import day_ctrl_pkg::*;
(
  input logic       clk,
  input logic       rst,
  input logic       tick,
  input logic       clear,
  input logic       running,
  input logic [1:0] ctrl_state
);

  a_tick_clear_excl: assert property (@(posedge clk) disable iff (rst) !(tick && clear));
  a_running_state:   assert property (@(posedge clk) disable iff (rst) running == (ctrl_state == ST_RUN));
  a_tick_not_clear:  assert property (@(posedge clk) disable iff (rst) tick |-> (ctrl_state != ST_CLEAR));

endmodule

// File: rtl/key_debounce.sv
// Synchronises one active-low push button and accepts a new level only after it has
// been stable for DEBOUNCE_CYCLES cycles; reports the accepted level and a one-cycle change pulse.
module key_debounce
  import day_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw,
  output logic pressed,
  output logic changed
);

  localparam int CW = (DEBOUNCE_CYCLES > 32'sd1) ? $clog2(DEBOUNCE_CYCLES) : 32'sd1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'sd1);

  logic [1:0]    sync_r;
  logic [CW-1:0] cnt_r;
  logic          pressed_r;
  logic          changed_r;
  logic          raw_pressed_s;

  assign raw_pressed_s = ~sync_r[1];
  assign pressed       = pressed_r;
  assign changed       = changed_r;

  // Two-stage synchroniser, idles at the released (high) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= 2'b11;
    end else begin
      sync_r <= {sync_r[0], key_raw};
    end
  end

  // Stability counter: any return to the accepted level restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= {CW{1'b0}};
      pressed_r <= 1'b0;
      changed_r <= 1'b0;
    end else begin
      changed_r <= 1'b0;
      if (raw_pressed_s == pressed_r) begin
        cnt_r <= {CW{1'b0}};
      end else if (cnt_r == CNT_LAST) begin
        cnt_r     <= {CW{1'b0}};
        pressed_r <= raw_pressed_s;
        changed_r <= 1'b1;
      end else begin
        cnt_r <= cnt_r + CW'(1'b1);
      end
    end
  end

endmodule

// File: rtl/day_counter_ctrl.sv
// Run/pause/step/speed sequencer: turns debounced KEY[1:0] into single-cycle tick/clear
// enables for a counter clocked directly by ADC_CLK_10.
module day_counter_ctrl
  import day_ctrl_pkg::*;
#(
  parameter int DIV_SLOW        = DEF_DIV_SLOW,
  parameter int DIV_FAST        = DEF_DIV_FAST,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
  input  logic              ADC_CLK_10,
  input  logic              reset,
  day_counter_ctrl_if.slave bus
);

  localparam int PW = $clog2(DIV_SLOW);
  localparam int HW = $clog2(HOLD_CYCLES + 32'sd1);
  localparam logic [PW-1:0] SLOW_LAST = PW'(DIV_SLOW - 32'sd1);
  localparam logic [PW-1:0] FAST_LAST = PW'(DIV_FAST - 32'sd1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(HOLD_CYCLES - 32'sd1);

  logic          k0_lvl_s, k0_chg_s, k1_lvl_s, k1_chg_s;
  logic          k0_press_s, k0_rel_s, k1_press_s;
  logic          clear_req_s, run_toggle_s;

  ctrl_state_e   state_r, state_n_s;
  logic          fast_r, fast_n_s;
  logic [PW-1:0] pre_r, pre_n_s, pre_last_s;
  logic          tick_n_s;
  logic [HW-1:0] hold_r;
  logic          swallow_r;
  logic          tick_r, clear_r, running_r;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk     (ADC_CLK_10),
    .rst     (reset),
    .key_raw (bus.KEY[0]),
    .pressed (k0_lvl_s),
    .changed (k0_chg_s)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk     (ADC_CLK_10),
    .rst     (reset),
    .key_raw (bus.KEY[1]),
    .pressed (k1_lvl_s),
    .changed (k1_chg_s)
  );

  assign k0_press_s   = k0_chg_s & k0_lvl_s;
  assign k0_rel_s     = k0_chg_s & ~k0_lvl_s;
  assign k1_press_s   = k1_chg_s & k1_lvl_s;
  // The request fires once, on the cycle the hold count reaches HOLD_CYCLES.
  assign clear_req_s  = k0_lvl_s & (hold_r == HOLD_PRE);
  assign run_toggle_s = k0_rel_s & ~swallow_r;
  assign pre_last_s   = fast_r ? FAST_LAST : SLOW_LAST;

  // KEY0 hold timer (saturating) and the flag that eats the release after a clear.
  always_ff @(posedge ADC_CLK_10 or posedge reset) begin
    if (reset) begin
      hold_r    <= {HW{1'b0}};
      swallow_r <= 1'b0;
    end else begin
      if (!k0_lvl_s) begin
        hold_r <= {HW{1'b0}};
      end else if (hold_r != HOLD_MAX) begin
        hold_r <= hold_r + HW'(1'b1);
      end else begin
        hold_r <= hold_r;
      end
      if (clear_req_s) begin
        swallow_r <= 1'b1;
      end else if (k0_press_s) begin
        swallow_r <= 1'b0;
      end else begin
        swallow_r <= swallow_r;
      end
    end
  end

  // Next state, speed, prescaler and tick; higher-priority events drop lower ones.
  always_comb begin
    state_n_s = state_r;
    fast_n_s  = fast_r;
    pre_n_s   = {PW{1'b0}};
    tick_n_s  = 1'b0;
    if (clear_req_s) begin
      state_n_s = ST_CLEAR;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          state_n_s = ST_PAUSE;
        end
        ST_PAUSE: begin
          if (run_toggle_s) begin
            state_n_s = ST_RUN;
          end else if (k1_press_s) begin
            tick_n_s = 1'b1;
          end else begin
            state_n_s = ST_PAUSE;
          end
        end
        ST_RUN: begin
          if (run_toggle_s) begin
            state_n_s = ST_PAUSE;
          end else if (k1_press_s) begin
            fast_n_s = ~fast_r;
          end else if (pre_r == pre_last_s) begin
            tick_n_s = 1'b1;
          end else begin
            pre_n_s = pre_r + PW'(1'b1);
          end
        end
        default: begin
          state_n_s = ST_CLEAR;
        end
      endcase
    end
  end

  // State and output registers; clear follows the CLEAR state by one cycle.
  always_ff @(posedge ADC_CLK_10 or posedge reset) begin
    if (reset) begin
      state_r   <= ST_CLEAR;
      fast_r    <= 1'b0;
      pre_r     <= {PW{1'b0}};
      tick_r    <= 1'b0;
      clear_r   <= 1'b0;
      running_r <= 1'b0;
    end else begin
      state_r   <= state_n_s;
      fast_r    <= fast_n_s;
      pre_r     <= pre_n_s;
      tick_r    <= tick_n_s;
      clear_r   <= (state_r == ST_CLEAR);
      running_r <= (state_n_s == ST_RUN);
    end
  end

  assign bus.tick       = tick_r;
  assign bus.clear      = clear_r;
  assign bus.running    = running_r;
  assign bus.fast       = fast_r;
  assign bus.ctrl_state = state_r;

endmodule
